// File: rtl/vga_scanner_pkg.sv
// Shared timing defaults (640x480@60), display_addr field layout and colour constants
// for the VGA scanner and its GPU-side peers.
package vga_scanner_pkg;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_VIS   = 480;
  localparam int DEF_V_FRONT = 10;

  localparam int ADDR_W  = 22;
  localparam int COORD_W = 10;
  localparam int VIS_BIT = 21;
  localparam int PAR_BIT = 20;
  localparam int X_MSB   = 19;
  localparam int X_LSB   = 10;
  localparam int Y_MSB   = 9;
  localparam int Y_LSB   = 0;

  localparam logic [2:0] RGB_BLACK = 3'b000;

  typedef logic [COORD_W-1:0] coord_t;

  // True when v lies in [lo, lo+len-1].
  function automatic logic in_range(input coord_t v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_scanner_if.sv
// Raster-position / colour link between the display scanner (master) and the GPU (slave).
interface vga_scanner_if;

  logic [vga_scanner_pkg::ADDR_W-1:0] display_addr;
  logic [2:0]                         display_data;

  modport master (output display_addr, input display_data);
  modport slave  (input display_addr, output display_data);

endinterface

// File: rtl/vga_tick_div.sv
// Pixel-clock divider: pixel_tick is high on the last sysclk of every CLK_DIV-cycle slot.
module vga_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic sysclk,
  input  logic rst,
  output logic pixel_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          tick_reg;

  always_comb begin
    count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
  end

  // The tick is registered so it is low during reset even when CLK_DIV is 1.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= (count_next == LAST);
    end
  end

  assign pixel_tick = tick_reg;

endmodule

// File: rtl/vga_scanner.sv
// VGA raster generator: counters, registered sync/blanking and colour capture from the GPU.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds test_mode).
module vga_scanner
  import vga_scanner_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int SYNC_POL = 0
) (
  input  logic                 sysclk,
  input  logic                 rst,
  vga_scanner_if.master        display,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 pixel_tick,
  output logic                 frame_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic [2:0]           vga_rgb
);

  localparam int H_TOTAL  = H_SYNC + H_BACK + H_VIS + H_FRONT;
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_VIS + V_FRONT;
  localparam int H_VIS_LO = H_SYNC + H_BACK;
  localparam int V_VIS_LO = V_SYNC + V_BACK;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic              tick;
  coord_t            x_reg, x_next;
  coord_t            y_reg, y_next;
  logic              par_reg, par_next;
  logic              x_wrap, y_wrap;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        rgb_reg;
  logic [2:0]        pix_colour;
  logic              hs_reg, vs_reg, fs_reg;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .sysclk     (sysclk),
    .rst        (rst),
    .pixel_tick (tick)
  );

  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    par_next = par_reg;
    x_wrap   = (x_reg == COORD_W'(H_TOTAL - 1));
    y_wrap   = (y_reg == COORD_W'(V_TOTAL - 1));
    if (tick) begin
      if (x_wrap) begin
        x_next = '0;
        if (y_wrap) begin
          y_next   = '0;
          par_next = ~par_reg;
        end else begin
          y_next = y_reg + 1'b1;
        end
      end else begin
        x_next = x_reg + 1'b1;
      end
    end
  end

  // display_addr tracks the next counter state so it changes together with x/y.
  always_comb begin
    addr_next                = '0;
    addr_next[VIS_BIT]       = in_range(x_next, H_VIS_LO, H_VIS) &&
                               in_range(y_next, V_VIS_LO, V_VIS);
    addr_next[PAR_BIT]       = par_next;
    addr_next[X_MSB:X_LSB]   = x_next;
    addr_next[Y_MSB:Y_LSB]   = y_next;
  end

`ifdef VGA_TEST_PATTERN_EN
  coord_t bar_off;
  always_comb begin
    bar_off    = x_reg - COORD_W'(H_VIS_LO);
    pix_colour = addr_reg[VIS_BIT] ? display.display_data : RGB_BLACK;
    if (test_mode && addr_reg[VIS_BIT]) begin
      pix_colour = bar_off[8:6];
    end
  end
`else
  // Blanking is forced here; the GPU's own output outside the visible area is ignored.
  always_comb begin
    pix_colour = addr_reg[VIS_BIT] ? display.display_data : RGB_BLACK;
  end
`endif

  always_ff @(posedge sysclk) begin
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      par_reg  <= 1'b0;
      addr_reg <= '0;
      rgb_reg  <= RGB_BLACK;
      hs_reg   <= ~SYNC_ACT;
      vs_reg   <= ~SYNC_ACT;
      fs_reg   <= 1'b0;
    end else begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      par_reg  <= par_next;
      addr_reg <= addr_next;
      fs_reg   <= tick && x_wrap && y_wrap;
      // Sync is decoded from the slot being captured so it lines up with vga_rgb.
      if (tick) begin
        rgb_reg <= pix_colour;
        hs_reg  <= (x_reg < COORD_W'(H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
        vs_reg  <= (y_reg < COORD_W'(V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
      end
    end
  end

  assign display.display_addr = addr_reg;
  assign pixel_tick           = tick;
  assign frame_start          = fs_reg;
  assign hsync                = hs_reg;
  assign vsync                = vs_reg;
  assign vga_rgb              = rgb_reg;

endmodule
